// File: rtl/user_bus_register_slave.sv
// Register bank behind the simplified user bus: NUM_REGS-1 byte-writable control
// registers plus one read-only status word at the highest index.
module user_bus_register_slave #(
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS           = 8
) (
    input  logic                                   ACLK,
    input  logic                                   ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          awaddr,
    input  logic                                   awvalid,
    output logic                                   awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        wstrb,
    input  logic                                   wvalid,
    output logic                                   wready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          araddr,
    input  logic                                   arvalid,
    output logic                                   arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          rdata,
    output logic                                   rvalid,
    input  logic                                   rready,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          status_in
);

    localparam int          DW      = C_S_AXI_DATA_WIDTH;
    localparam int          NB      = DW / 8;
    localparam int          IDX_LSB = $clog2(NB);
    localparam int          IW      = $clog2(NUM_REGS);
    localparam int unsigned NRW     = NUM_REGS - 1;
    localparam logic [IW-1:0] RO_IDX = IW'(NUM_REGS - 1);

    typedef enum logic { W_ADDR, W_DATA } wstate_e;
    typedef enum logic { R_ADDR, R_DATA } rstate_e;

    wstate_e           wstate_q, wstate_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic [IW-1:0]     aw_idx_q, aw_idx_d;

    rstate_e           rstate_q, rstate_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DW-1:0]     rdata_q, rdata_d;

    logic [DW-1:0]     regs_q [NUM_REGS];
    logic [DW-1:0]     regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pulse_q, pulse_d;

    logic              w_commit;
    logic [IW-1:0]     ar_idx;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{awaddr, araddr};
    assign ar_idx           = araddr[IDX_LSB +: IW];
    assign w_commit         = (wstate_q == W_DATA) && wvalid && wready_q;

    // ---------------- write channel FSM ----------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q  <= W_ADDR;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            aw_idx_q  <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            aw_idx_q  <= aw_idx_d;
        end
    end

    // awready is held low through reset and rises on the first edge afterwards.
    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        aw_idx_d  = aw_idx_q;
        unique case (wstate_q)
            W_ADDR: begin
                awready_d = 1'b1;
                wready_d  = 1'b0;
                if (awvalid && awready_q) begin
                    aw_idx_d  = awaddr[IDX_LSB +: IW];
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    wstate_d  = W_DATA;
                end
            end
            W_DATA: begin
                awready_d = 1'b0;
                wready_d  = 1'b1;
                if (wvalid && wready_q) begin
                    awready_d = 1'b1;
                    wready_d  = 1'b0;
                    wstate_d  = W_ADDR;
                end
            end
        endcase
    end

    // ---------------- register bank ----------------
    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        if (w_commit && (aw_idx_q != RO_IDX)) begin
            pulse_d[aw_idx_q] = 1'b1;
            for (int unsigned b = 0; b < NB; b++) begin
                if (wstrb[b]) begin
                    regs_d[aw_idx_q][b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs_q  <= '{default: '0};
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    // ---------------- read channel FSM ----------------
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rstate_q  <= R_ADDR;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    // Reads sample regs_q, so a same-edge write commit is seen as the old value.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        unique case (rstate_q)
            R_ADDR: begin
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
                if (arvalid && arready_q) begin
                    rdata_d   = (ar_idx == RO_IDX) ? status_in : regs_q[ar_idx];
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rstate_d  = R_DATA;
                end
            end
            R_DATA: begin
                rvalid_d = 1'b1;
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_ADDR;
                end
            end
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NRW; i++) begin
            reg_out[i*DW +: DW] = regs_q[i];
        end
    end

    assign awready      = awready_q;
    assign wready       = wready_q;
    assign arready      = arready_q;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_user_bus_register_slave.sv
// Directed plus randomized bench for user_bus_register_slave, checked against an
// array model of the register file with immediate assertions.
`timescale 1ns/1ps
module tb_user_bus_register_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 8;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [AW-1:0]     awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [DW-1:0]     wdata = '0;
    logic [DW/8-1:0]   wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [AW-1:0]     araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [DW-1:0]     rdata;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [NR*DW-1:0]  reg_out;
    logic [NR-1:0]     reg_wr_pulse;
    logic [DW-1:0]     status_in = '0;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] mdl [NR];

    user_bus_register_slave #(
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_S_AXI_DATA_WIDTH(DW),
        .NUM_REGS(NR)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse), .status_in(status_in)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    function automatic int word_idx(input logic [AW-1:0] a);
        return int'((a >> 2) % NR);
    endfunction

    function automatic logic [NR*DW-1:0] exp_regout();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR - 1; i++) v[i*DW +: DW] = mdl[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
    endtask

    task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [3:0] s, output logic [NR-1:0] p);
        int idx;
        idx = word_idx(a);
        p = '0;
        if (idx != NR - 1) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[idx][b*8 +: 8] = d[b*8 +: 8];
            p[idx] = 1'b1;
        end
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        logic [NR-1:0] ep;
        int n;
        awaddr = a; awvalid = 1'b1; n = 0;
        while (awready !== 1'b1 && n < 20) begin step(); n++; end
        check("aw_ready", awready, 1);
        step();
        awvalid = 1'b0;
        wdata = d; wstrb = s; wvalid = 1'b1; n = 0;
        while (wready !== 1'b1 && n < 20) begin step(); n++; end
        check("w_ready", wready, 1);
        step();
        wvalid = 1'b0;
        model_write(a, d, s, ep);
        check("wr_pulse", reg_wr_pulse, ep);
        check("reg_out", reg_out, exp_regout());
        check("aw_ready_back", awready, 1);
        step();
        check("pulse_clear", reg_wr_pulse, 0);
    endtask

    task automatic bus_read(input logic [AW-1:0] a, input int hold);
        logic [DW-1:0] e;
        int idx, n;
        araddr = a; arvalid = 1'b1; n = 0;
        while (arready !== 1'b1 && n < 20) begin step(); n++; end
        check("ar_ready", arready, 1);
        idx = word_idx(a);
        e = (idx == NR - 1) ? status_in : mdl[idx];
        step();
        arvalid = 1'b0;
        status_in = $urandom;
        check("rvalid", rvalid, 1);
        check("rdata", rdata, e);
        for (int k = 0; k < hold; k++) begin
            step();
            check("rvalid_hold", rvalid, 1);
            check("rdata_hold", rdata, e);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("rvalid_drop", rvalid, 0);
        check("ar_ready_back", arready, 1);
    endtask

    initial begin
        logic [NR-1:0] ep;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        model_clear();

        // reset and idle
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_reg_out", reg_out, 0);
        check("rst_pulse", reg_wr_pulse, 0);
        ARESET = 1'b0;
        #1;
        check("post_rst_awready_low", awready, 0);
        step();
        check("idle_awready", awready, 1);
        check("idle_arready", arready, 1);
        check("idle_rvalid", rvalid, 0);
        check("idle_reg_out", reg_out, 0);

        // full write then read with back-pressure
        bus_write(32'h04, 32'hDEADBEEF, 4'hF);
        check("reg1_value", reg_out[63:32], 32'hDEADBEEF);
        bus_read(32'h04, 3);

        // byte strobes and address aliasing
        bus_write(32'h08, 32'h11223344, 4'hF);
        bus_write(32'h28, 32'hAABBCCDD, 4'h5);
        check("reg2_alias", reg_out[95:64], 32'h11BB33DD);

        // write with zero strobes still pulses
        bus_write(32'h14, 32'hFFFFFFFF, 4'h0);

        // status word and read-only write
        status_in = 32'h0000CAFE;
        bus_write(32'h1C, 32'h00001234, 4'hF);
        status_in = 32'h0000CAFE;
        bus_read(32'h1C, 0);

        // W presented before AW
        wdata = 32'h0BADF00D; wstrb = 4'hF; wvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("w_early_wready", wready, 0);
        end
        awaddr = 32'h10; awvalid = 1'b1;
        check("w_early_awready", awready, 1);
        step();
        awvalid = 1'b0;
        check("w_early_wready_up", wready, 1);
        step();
        wvalid = 1'b0;
        model_write(32'h10, 32'h0BADF00D, 4'hF, ep);
        check("w_early_pulse", reg_wr_pulse, ep);
        check("w_early_reg_out", reg_out, exp_regout());
        step();
        check("w_early_single", reg_wr_pulse, 0);
        check("w_early_wready_down", wready, 0);

        // AR and W commit to the same register on the same edge
        bus_write(32'h0C, 32'h9, 4'hF);
        awaddr = 32'h0C; awvalid = 1'b1;
        check("coll_awready", awready, 1);
        step();
        awvalid = 1'b0;
        araddr = 32'h0C; arvalid = 1'b1;
        wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
        check("coll_wready", wready, 1);
        check("coll_arready", arready, 1);
        step();
        arvalid = 1'b0; wvalid = 1'b0;
        model_write(32'h0C, 32'h5, 4'hF, ep);
        check("coll_rvalid", rvalid, 1);
        check("coll_rdata_old", rdata, 32'h9);
        check("coll_reg3_new", reg_out[127:96], 32'h5);
        check("coll_pulse", reg_wr_pulse, ep);
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("coll_rvalid_drop", rvalid, 0);

        // randomized traffic against the model
        for (int it = 0; it < 60; it++) begin
            ra = $urandom;
            rd = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                bus_write(ra, rd, 4'($urandom_range(0, 15)));
            end else begin
                status_in = $urandom;
                bus_read(ra, $urandom_range(0, 3));
            end
        end

        // reset in the middle of a read
        bus_write(32'h04, 32'h12345678, 4'hF);
        araddr = 32'h04; arvalid = 1'b1;
        check("mid_rst_arready", arready, 1);
        step();
        arvalid = 1'b0;
        check("mid_rst_rvalid_pre", rvalid, 1);
        #2;
        ARESET = 1'b1;
        #1;
        model_clear();
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_reg_out", reg_out, 0);
        check("mid_rst_arready_low", arready, 0);
        step();
        step();
        #2;
        ARESET = 1'b0;
        #1;
        check("mid_rst_awready_low", awready, 0);
        step();
        check("mid_rst_awready_up", awready, 1);
        check("mid_rst_arready_up", arready, 1);
        bus_read(32'h04, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
